// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
//   bp_cnt_t    : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   btb_entry_t : one BTB line. Tag and target are held at the widest supported
//                 size. Narrower configurations zero-extend into them, so the
//                 unused upper bits are constant and synthesis removes them.
//   sat_update  : next counter state for a resolved direction
package bp_pkg;

  localparam int BP_MAX_PC_W  = 32;
  localparam int BP_MAX_TAG_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  typedef struct packed {
    logic                    valid;
    logic                    is_jump;
    logic [BP_MAX_TAG_W-1:0] tag;
    logic [BP_MAX_PC_W-1:0]  target;
  } btb_entry_t;

  // Move one step toward the resolved direction; the strong states hold.
  function automatic bp_cnt_t sat_update(bp_cnt_t cnt, logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = bp_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = bp_cnt_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer.
//   clk_i, rst_i : clock, synchronous active-low clear of all valid bits
//   rd_idx_i     : combinational read index (fetch side)
//   rd_entry_o   : entry at rd_idx_i; shows the contents from before any
//                  write that is happening in the same cycle
//   wr_en_i      : write wr_entry_i to wr_idx_i at the clock edge
//   wr_idx_i     : write index
//   wr_entry_i   : entry to write; an existing entry at that index is overwritten
module bp_btb
  import bp_pkg::*;
#(
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output btb_entry_t           rd_entry_o,
  input  logic                 wr_en_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  btb_entry_t           wr_entry_i
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  btb_entry_t mem_q [DEPTH];

  // Only the valid bits are cleared; tag/target are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the pipelined RV32I core.
//   Fetch side   : pcF_i -> predict_taken_o / predict_target_o / predict_idx_o (comb)
//   Execute side : upd_* describe the resolved control-flow instruction.
//                  The block trains the BTB, the counter table and the GHR.
//                  It also produces mispredict_o and redirect_pc_o (comb).
//   Perf         : br_count_o counts resolved branches and JALs,
//                  miss_count_o counts mispredicts; both saturate.
//   clk_i / rst_i: rising-edge clock, synchronous active-low reset.
// GSHARE=0 indexes the counter table with pc[IDX_WIDTH+1:2].
// GSHARE=1 XORs that index with the global history register.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int IDX_WIDTH = 6,
  parameter int TAG_WIDTH = 8,
  parameter int GSHARE    = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PC_WIDTH-1:0]  pcF_i,
  output logic                 predict_taken_o,
  output logic [PC_WIDTH-1:0]  predict_target_o,
  output logic [IDX_WIDTH-1:0] predict_idx_o,
  input  logic                 upd_valid_i,
  input  logic [PC_WIDTH-1:0]  upd_pc_i,
  input  logic [IDX_WIDTH-1:0] upd_idx_i,
  input  logic                 upd_is_branch_i,
  input  logic                 upd_is_jump_i,
  input  logic                 upd_taken_i,
  input  logic [PC_WIDTH-1:0]  upd_target_i,
  input  logic                 upd_pred_taken_i,
  input  logic [PC_WIDTH-1:0]  upd_pred_target_i,
  output logic                 mispredict_o,
  output logic [PC_WIDTH-1:0]  redirect_pc_o,
  output logic [CNT_WIDTH-1:0] br_count_o,
  output logic [CNT_WIDTH-1:0] miss_count_o
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  if (IDX_WIDTH + TAG_WIDTH + 2 > PC_WIDTH) begin : g_bad_geometry
    $error("branch_predictor: IDX_WIDTH+TAG_WIDTH+2 must not exceed PC_WIDTH");
  end
  if (PC_WIDTH > BP_MAX_PC_W || TAG_WIDTH > BP_MAX_TAG_W) begin : g_bad_width
    $error("branch_predictor: PC_WIDTH/TAG_WIDTH exceed the BTB entry size");
  end
  if (IDX_WIDTH < 2) begin : g_bad_idx
    $error("branch_predictor: IDX_WIDTH must be at least 2");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  bp_cnt_t              cnt_q [DEPTH];
  logic [IDX_WIDTH-1:0] ghr_q;

  // ---- fetch: combinational lookup ----
  logic [IDX_WIDTH-1:0] f_bidx;
  logic [TAG_WIDTH-1:0] f_tag;
  btb_entry_t           f_entry;
  logic                 f_hit;
  logic                 unused_pcf;

  assign f_bidx     = pcF_i[IDX_WIDTH+1:2];
  assign f_tag      = pcF_i[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];
  // pc[1:0] and the bits above the tag do not take part in the lookup.
  assign unused_pcf = ^pcF_i;

  assign predict_idx_o    = (GSHARE != 0) ? (f_bidx ^ ghr_q) : f_bidx;
  assign f_hit            = f_entry.valid && (f_entry.tag == BP_MAX_TAG_W'(f_tag));
  // JAL entries redirect unconditionally; branches need a taken-leaning counter.
  assign predict_taken_o  = f_hit && (f_entry.is_jump || cnt_q[predict_idx_o][1]);
  assign predict_target_o = f_entry.target[PC_WIDTH-1:0];

  // ---- execute: resolution and training ----
  logic                 e_qual;
  logic [IDX_WIDTH-1:0] e_bidx;
  logic [TAG_WIDTH-1:0] e_tag;
  btb_entry_t           e_entry;

  // JALR arrives with both type flags low and is neither trained nor checked.
  assign e_qual = upd_valid_i && (upd_is_branch_i || upd_is_jump_i);
  assign e_bidx = upd_pc_i[IDX_WIDTH+1:2];
  assign e_tag  = upd_pc_i[IDX_WIDTH+TAG_WIDTH+1:IDX_WIDTH+2];

  assign mispredict_o = e_qual &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_WIDTH'(4);

  always_comb begin
    e_entry         = '0;
    e_entry.valid   = 1'b1;
    e_entry.is_jump = upd_is_jump_i;
    e_entry.tag     = BP_MAX_TAG_W'(e_tag);
    e_entry.target  = BP_MAX_PC_W'(upd_target_i);
  end

  // Only taken outcomes allocate; a not-taken outcome leaves the BTB alone.
  bp_btb #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_btb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (f_bidx),
    .rd_entry_o (f_entry),
    .wr_en_i    (e_qual && upd_taken_i),
    .wr_idx_i   (e_bidx),
    .wr_entry_i (e_entry)
  );

  // ---- state update at the clock edge (reset wins over a same-cycle update) ----
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= WNT;
      ghr_q        <= '0;
      br_count_o   <= '0;
      miss_count_o <= '0;
    end else begin
      if (e_qual && upd_is_branch_i) begin
        cnt_q[upd_idx_i] <= sat_update(cnt_q[upd_idx_i], upd_taken_i);
        if (GSHARE != 0) ghr_q <= {ghr_q[IDX_WIDTH-2:0], upd_taken_i};
      end
      if (e_qual)       br_count_o   <= sat_inc(br_count_o);
      if (mispredict_o) miss_count_o <= sat_inc(miss_count_o);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor. Two instances share all inputs.
//   d0: bimodal with 32-bit perf counters.
//   d1: gshare with 4-bit perf counters, so saturation is reachable.
// Stimulus pushes expected values into a queue.
// A monitor on the falling edge pops each entry and compares it with the DUT.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        upd_valid, upd_br, upd_jmp, upd_taken, upd_ptaken;
  logic [31:0] upd_pc, upd_tgt, upd_ptgt;
  logic [5:0]  upd_idx;

  logic        d0_taken, d0_misp, d1_taken, d1_misp;
  logic [31:0] d0_target, d0_redir, d0_br, d0_miss, d1_target, d1_redir;
  logic [5:0]  d0_idx, d1_idx;
  logic [3:0]  d1_br, d1_miss;

  always #5 clk = ~clk;

  branch_predictor #(.PC_WIDTH(32), .IDX_WIDTH(6), .TAG_WIDTH(8), .GSHARE(0), .CNT_WIDTH(32)) d0 (
    .clk_i(clk), .rst_i(rst), .pcF_i(pcf),
    .predict_taken_o(d0_taken), .predict_target_o(d0_target), .predict_idx_o(d0_idx),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx),
    .upd_is_branch_i(upd_br), .upd_is_jump_i(upd_jmp), .upd_taken_i(upd_taken),
    .upd_target_i(upd_tgt), .upd_pred_taken_i(upd_ptaken), .upd_pred_target_i(upd_ptgt),
    .mispredict_o(d0_misp), .redirect_pc_o(d0_redir),
    .br_count_o(d0_br), .miss_count_o(d0_miss));

  branch_predictor #(.PC_WIDTH(32), .IDX_WIDTH(6), .TAG_WIDTH(8), .GSHARE(1), .CNT_WIDTH(4)) d1 (
    .clk_i(clk), .rst_i(rst), .pcF_i(pcf),
    .predict_taken_o(d1_taken), .predict_target_o(d1_target), .predict_idx_o(d1_idx),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx),
    .upd_is_branch_i(upd_br), .upd_is_jump_i(upd_jmp), .upd_taken_i(upd_taken),
    .upd_target_i(upd_tgt), .upd_pred_taken_i(upd_ptaken), .upd_pred_target_i(upd_ptgt),
    .mispredict_o(d1_misp), .redirect_pc_o(d1_redir),
    .br_count_o(d1_br), .miss_count_o(d1_miss));

  // Observation kinds: 0..6 for d0, 10..16 for d1.
  localparam int K_TK = 0, K_TG = 1, K_IX = 2, K_MP = 3, K_RD = 4, K_BR = 5, K_MS = 6;

  string       nm_q [$];
  int          kd_q [$];
  logic [31:0] ex_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] observe(input int k);
    case (k)
      0:  return 32'(d0_taken);
      1:  return d0_target;
      2:  return 32'(d0_idx);
      3:  return 32'(d0_misp);
      4:  return d0_redir;
      5:  return d0_br;
      6:  return d0_miss;
      10: return 32'(d1_taken);
      11: return d1_target;
      12: return 32'(d1_idx);
      13: return 32'(d1_misp);
      14: return d1_redir;
      15: return 32'(d1_br);
      16: return 32'(d1_miss);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    string       n;
    int          k;
    logic [31:0] e, a;
    while (kd_q.size() > 0) begin
      n = nm_q.pop_front();
      k = kd_q.pop_front();
      e = ex_q.pop_front();
      a = observe(k);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", n, a, e);
      end
    end
  end

  task automatic chk(input string n, input int k, input logic [31:0] v);
    nm_q.push_back(n);
    kd_q.push_back(k);
    ex_q.push_back(v);
  endtask

  task automatic clr();
    upd_valid = 0; upd_br = 0; upd_jmp = 0; upd_taken = 0; upd_ptaken = 0;
    upd_pc = 0; upd_tgt = 0; upd_ptgt = 0; upd_idx = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic br,
                     input logic jmp, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_idx = idx; upd_br = br; upd_jmp = jmp;
    upd_taken = tk; upd_tgt = tgt; upd_ptaken = ptk; upd_ptgt = ptgt;
  endtask

  // Hand-derived gshare trace for alternating T/N at pc 0x100 (bidx 0).
  int g_idx  [20] = '{0, 1, 2, 5, 10, 21, 42, 21, 42, 21, 42, 21, 42, 21, 42, 21, 42, 21, 42, 21};
  int g_pred [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int g_miss [20] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int tk;
    rst = 0; pcf = 32'h100; clr();
    repeat (3) @(posedge clk);
    #1; rst = 1;
    chk("rst_taken", K_TK, 0); chk("rst_idx", K_IX, 0); chk("rst_misp", K_MP, 0);
    chk("rst_br", K_BR, 0); chk("rst_miss", K_MS, 0);
    chk("rst_d1_taken", 10 + K_TK, 0); chk("rst_d1_br", 10 + K_BR, 0);
    cyc();
    pcf = 32'h1FC; chk("idx_1fc", K_IX, 32'h3F); chk("taken_1fc", K_TK, 0);
    cyc();
    // Branch 0x100 taken to 0x80; the same-cycle lookup still sees the empty entry.
    pcf = 32'h100; upd(32'h100, 0, 1, 0, 1, 32'h80, 0, 0);
    chk("b1_misp", K_MP, 1); chk("b1_redir", K_RD, 32'h80); chk("b1_same_cyc", K_TK, 0);
    chk("b1_br_old", K_BR, 0);
    cyc();
    chk("b1_taken", K_TK, 1); chk("b1_target", K_TG, 32'h80);
    chk("b1_br", K_BR, 1); chk("b1_miss", K_MS, 1); chk("idle_misp", K_MP, 0);
    cyc();
    upd(32'h100, 0, 1, 0, 0, 32'h80, 1, 32'h80);          // WT -> WNT
    chk("n1_misp", K_MP, 1); chk("n1_redir", K_RD, 32'h104);
    cyc();
    chk("n1_taken", K_TK, 0); chk("n1_br", K_BR, 2); chk("n1_miss", K_MS, 2);
    upd(32'h100, 0, 1, 0, 0, 32'h80, 0, 0);               // WNT -> SNT
    chk("n2_misp", K_MP, 0); chk("n2_redir", K_RD, 32'h104);
    cyc();
    upd(32'h100, 0, 1, 0, 0, 32'h80, 0, 0);               // SNT held
    chk("n3_misp", K_MP, 0); chk("n2_taken", K_TK, 0);
    cyc();
    chk("n3_taken", K_TK, 0); chk("n3_br", K_BR, 4); chk("n3_miss", K_MS, 2);
    upd(32'h100, 0, 1, 0, 1, 32'h80, 0, 0);               // SNT -> WNT
    chk("t4_misp", K_MP, 1);
    cyc();
    chk("t4_taken", K_TK, 0); chk("t4_br", K_BR, 5); chk("t4_miss", K_MS, 3);
    // JAL 0x200 -> 0x400 shares BTB slot 0 with 0x100 (different tag).
    pcf = 32'h200; chk("j1_pre", K_TK, 0);
    upd(32'h200, 0, 0, 1, 1, 32'h400, 0, 0);
    chk("j1_misp", K_MP, 1); chk("j1_redir", K_RD, 32'h400);
    cyc();
    chk("j1_taken", K_TK, 1); chk("j1_target", K_TG, 32'h400);
    chk("j1_br", K_BR, 6); chk("j1_miss", K_MS, 4);
    upd(32'h200, 0, 0, 1, 1, 32'h400, 1, 32'h400);
    chk("j2_misp", K_MP, 0); chk("j2_redir", K_RD, 32'h400);
    cyc();
    chk("j2_taken", K_TK, 1); chk("j2_br", K_BR, 7);
    upd(32'h100, 0, 1, 0, 0, 32'h80, 0, 0);               // counter WNT -> SNT
    chk("n5_misp", K_MP, 0);
    cyc();
    // Alias: 0x100 and 0x200 map to the same BTB slot.
    pcf = 32'h100; chk("a1_tagmiss", K_TK, 0);
    upd(32'h100, 0, 1, 0, 1, 32'h80, 0, 0);               // SNT -> WNT, BTB tag 1
    chk("a1_misp", K_MP, 1);
    cyc();
    chk("a1_hit_wnt", K_TK, 0); chk("a1_br", K_BR, 9); chk("a1_miss", K_MS, 5);
    upd(32'h200, 0, 1, 0, 1, 32'h300, 0, 0);              // WNT -> WT, BTB tag 2
    chk("a2_misp", K_MP, 1); chk("a2_redir", K_RD, 32'h300);
    cyc();
    chk("a2_old_tag", K_TK, 0);
    cyc();
    pcf = 32'h200; chk("a3_taken", K_TK, 1); chk("a3_target", K_TG, 32'h300);
    upd(32'h200, 0, 1, 0, 1, 32'h340, 1, 32'h300);        // right direction, wrong target
    chk("tgt_misp", K_MP, 1); chk("tgt_redir", K_RD, 32'h340);
    cyc();
    chk("tgt_new", K_TG, 32'h340); chk("tgt_br", K_BR, 11); chk("tgt_miss", K_MS, 7);
    upd(32'h500, 0, 0, 0, 1, 32'h900, 0, 0);              // JALR: ignored
    chk("jalr_misp", K_MP, 0); chk("jalr_redir", K_RD, 32'h900);
    cyc();
    pcf = 32'h500; chk("jalr_noalloc", K_TK, 0);
    chk("jalr_br", K_BR, 11); chk("jalr_miss", K_MS, 7);
    upd(32'h100, 0, 1, 0, 1, 32'h80, 0, 0); upd_valid = 0;
    chk("novalid_misp", K_MP, 0);
    cyc();
    upd(32'h200, 0, 1, 0, 0, 32'h340, 1, 32'h340);        // not-taken keeps the entry
    chk("nt_misp", K_MP, 1); chk("nt_redir", K_RD, 32'h204);
    cyc();
    pcf = 32'h200; chk("nt_keep", K_TK, 1); chk("nt_keep_tg", K_TG, 32'h340);
    chk("nt_br", K_BR, 12); chk("nt_miss", K_MS, 8);
    cyc();

    // gshare phase on d1
    rst = 0; cyc(); cyc(); rst = 1;
    pcf = 32'h100;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("g%0d_idx", i), 10 + K_IX, 32'(g_idx[i]));
      chk($sformatf("g%0d_pred", i), 10 + K_TK, 32'(g_pred[i]));
      if (g_pred[i] != 0) chk($sformatf("g%0d_tgt", i), 10 + K_TG, 32'h80);
      chk($sformatf("g%0d_br", i), 10 + K_BR, (i < 15) ? 32'(i) : 32'd15);
      chk($sformatf("g%0d_miss", i), 10 + K_MS, 32'(g_miss[i]));
      cyc();
      tk = (i % 2 == 0) ? 1 : 0;
      upd(32'h100, g_idx[i][5:0], 1, 0, tk[0], 32'h80, g_pred[i][0],
          (g_pred[i] != 0) ? 32'h80 : 32'h0);
      chk($sformatf("g%0d_misp", i), 10 + K_MP, 32'(tk != g_pred[i]));
      cyc();
    end
    chk("g_end_br_sat", 10 + K_BR, 15); chk("g_end_miss", 10 + K_MS, 4);
    cyc();
    // Reset asserted together with a qualifying update: the update is lost.
    rst = 0; upd(32'h100, 6'd42, 1, 0, 1, 32'h80, 1, 32'h80);
    cyc();
    rst = 1;
    chk("mr_d1_idx", 10 + K_IX, 0); chk("mr_d1_taken", 10 + K_TK, 0);
    chk("mr_d1_br", 10 + K_BR, 0); chk("mr_d1_miss", 10 + K_MS, 0);
    chk("mr_d0_taken", K_TK, 0); chk("mr_d0_br", K_BR, 0); chk("mr_d0_miss", K_MS, 0);
    cyc();
    vectors++;
    if (kd_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending, required 0", kd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
